// File: rtl/axi4_mgr_arb.sv
// axi4_mgr_arb: shares one axi4_mgr between NUM_REQ clients.
// The write and read channels each have their own round-robin arbiter and
// IDLE/BUSY sequencer. A granted client's address/data/count are captured and
// presented to the manager until its completion pulse returns. The result is
// then routed back to that client only.
module axi4_mgr_arb #(
   parameter int NUM_REQ          = 4,
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 64,
   parameter int DATA_COUNT_WIDTH = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rstn_i,
   input  logic [NUM_REQ-1:0]                     wr_req_i,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      wr_addr_i,
   input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]      wr_data_i,
   input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]    wr_count_i,
   output logic [NUM_REQ-1:0]                     wr_gnt_o,
   output logic [NUM_REQ-1:0]                     wr_done_o,
   output logic [1:0]                             wr_err_o,
   input  logic [NUM_REQ-1:0]                     rd_req_i,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      rd_addr_i,
   input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]    rd_count_i,
   output logic [NUM_REQ-1:0]                     rd_gnt_o,
   output logic [NUM_REQ-1:0]                     rd_done_o,
   output logic [1:0]                             rd_err_o,
   output logic [AXI_DATA_WIDTH-1:0]              rd_data_o,
   output logic [1:0]                             mgr_req_o,
   output logic [AXI_ADDR_WIDTH-1:0]              mgr_wr_addr_o,
   output logic [AXI_ADDR_WIDTH-1:0]              mgr_rd_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]              mgr_data_o,
   output logic [DATA_COUNT_WIDTH-1:0]            mgr_wr_count_o,
   output logic [DATA_COUNT_WIDTH-1:0]            mgr_rd_count_o,
   input  logic [1:0]                             mgr_rsp_i,
   input  logic [1:0]                             mgr_wr_err_i,
   input  logic [1:0]                             mgr_rd_err_i,
   input  logic [AXI_DATA_WIDTH-1:0]              mgr_data_i
);

   localparam int N  = NUM_REQ;
   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;
   localparam int CW = DATA_COUNT_WIDTH;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ERR_SLVERR = 2'b10;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // Round-robin pick: returns {found, index}; the requester closest at or after ptr wins.
   function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          idx;
      res = '0;
      // walk offsets from farthest to nearest so the nearest requester is kept last
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   // Pointer to the client after k, wrapping N-1 -> 0.
   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] k);
      return (int'(k) == N - 1) ? '0 : k + 1'b1;
   endfunction

   // write channel state (_p0 = next value, _p1 = registered)
   state_t          wr_state_p0, wr_state_p1;
   logic [IW-1:0]   wr_ptr_p0,   wr_ptr_p1;
   logic [IW-1:0]   wr_sel_p0,   wr_sel_p1;
   logic [AW-1:0]   wr_addr_p0,  wr_addr_p1;
   logic [DW-1:0]   wr_data_p0,  wr_data_p1;
   logic [CW-1:0]   wr_count_p0, wr_count_p1;
   logic [N-1:0]    wr_gnt_p0,   wr_gnt_p1;
   logic [N-1:0]    wr_done_p0,  wr_done_p1;
   logic [1:0]      wr_err_p0,   wr_err_p1;
   logic [IW:0]     wr_pick;
   logic [IW-1:0]   wr_k;

   // read channel state
   state_t          rd_state_p0, rd_state_p1;
   logic [IW-1:0]   rd_ptr_p0,   rd_ptr_p1;
   logic [IW-1:0]   rd_sel_p0,   rd_sel_p1;
   logic [AW-1:0]   rd_addr_p0,  rd_addr_p1;
   logic [CW-1:0]   rd_count_p0, rd_count_p1;
   logic [N-1:0]    rd_gnt_p0,   rd_gnt_p1;
   logic [N-1:0]    rd_done_p0,  rd_done_p1;
   logic [1:0]      rd_err_p0,   rd_err_p1;
   logic [DW-1:0]   rd_data_p0,  rd_data_p1;
   logic [IW:0]     rd_pick;
   logic [IW-1:0]   rd_k;

   // Write FSM next state: arbitrate and capture in IDLE, wait for rsp[0] in BUSY.
   always_comb begin
      wr_state_p0 = wr_state_p1;
      wr_ptr_p0   = wr_ptr_p1;
      wr_sel_p0   = wr_sel_p1;
      wr_addr_p0  = wr_addr_p1;
      wr_data_p0  = wr_data_p1;
      wr_count_p0 = wr_count_p1;
      wr_gnt_p0   = '0;
      wr_done_p0  = '0;
      wr_err_p0   = '0;
      wr_pick     = rr_pick(wr_req_i, wr_ptr_p1);
      wr_k        = wr_pick[IW-1:0];
      case (wr_state_p1)
         IDLE: begin
            if (wr_pick[IW]) begin
               wr_sel_p0       = wr_k;
               wr_ptr_p0       = rr_next(wr_k);
               wr_gnt_p0[wr_k] = 1'b1;
               wr_addr_p0      = wr_addr_i[wr_k*AW +: AW];
               wr_data_p0      = wr_data_i[wr_k*DW +: DW];
               wr_count_p0     = wr_count_i[wr_k*CW +: CW];
               // a zero-beat transfer is answered locally with SLVERR and never issued
               if (wr_count_i[wr_k*CW +: CW] == '0) begin
                  wr_done_p0[wr_k] = 1'b1;
                  wr_err_p0        = ERR_SLVERR;
               end else begin
                  wr_state_p0 = BUSY;
               end
            end
         end
         BUSY: begin
            if (mgr_rsp_i[0]) begin
               wr_done_p0[wr_sel_p1] = 1'b1;
               wr_err_p0             = mgr_wr_err_i;
               wr_state_p0           = IDLE;
            end
         end
         default: wr_state_p0 = IDLE;
      endcase
   end

   // Read FSM next state: same sequencing as write, also capturing read data on rsp[1].
   always_comb begin
      rd_state_p0 = rd_state_p1;
      rd_ptr_p0   = rd_ptr_p1;
      rd_sel_p0   = rd_sel_p1;
      rd_addr_p0  = rd_addr_p1;
      rd_count_p0 = rd_count_p1;
      rd_data_p0  = rd_data_p1;
      rd_gnt_p0   = '0;
      rd_done_p0  = '0;
      rd_err_p0   = '0;
      rd_pick     = rr_pick(rd_req_i, rd_ptr_p1);
      rd_k        = rd_pick[IW-1:0];
      case (rd_state_p1)
         IDLE: begin
            if (rd_pick[IW]) begin
               rd_sel_p0       = rd_k;
               rd_ptr_p0       = rr_next(rd_k);
               rd_gnt_p0[rd_k] = 1'b1;
               rd_addr_p0      = rd_addr_i[rd_k*AW +: AW];
               rd_count_p0     = rd_count_i[rd_k*CW +: CW];
               if (rd_count_i[rd_k*CW +: CW] == '0) begin
                  rd_done_p0[rd_k] = 1'b1;
                  rd_err_p0        = ERR_SLVERR;
               end else begin
                  rd_state_p0 = BUSY;
               end
            end
         end
         BUSY: begin
            if (mgr_rsp_i[1]) begin
               rd_done_p0[rd_sel_p1] = 1'b1;
               rd_err_p0             = mgr_rd_err_i;
               rd_data_p0            = mgr_data_i;
               rd_state_p0           = IDLE;
            end
         end
         default: rd_state_p0 = IDLE;
      endcase
   end

   // Write channel registers; reset drops any in-flight transfer silently.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_state_p1 <= IDLE;
         wr_ptr_p1   <= '0;
         wr_sel_p1   <= '0;
         wr_addr_p1  <= '0;
         wr_data_p1  <= '0;
         wr_count_p1 <= '0;
         wr_gnt_p1   <= '0;
         wr_done_p1  <= '0;
         wr_err_p1   <= '0;
      end else begin
         wr_state_p1 <= wr_state_p0;
         wr_ptr_p1   <= wr_ptr_p0;
         wr_sel_p1   <= wr_sel_p0;
         wr_addr_p1  <= wr_addr_p0;
         wr_data_p1  <= wr_data_p0;
         wr_count_p1 <= wr_count_p0;
         wr_gnt_p1   <= wr_gnt_p0;
         wr_done_p1  <= wr_done_p0;
         wr_err_p1   <= wr_err_p0;
      end
   end

   // Read channel registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_state_p1 <= IDLE;
         rd_ptr_p1   <= '0;
         rd_sel_p1   <= '0;
         rd_addr_p1  <= '0;
         rd_count_p1 <= '0;
         rd_data_p1  <= '0;
         rd_gnt_p1   <= '0;
         rd_done_p1  <= '0;
         rd_err_p1   <= '0;
      end else begin
         rd_state_p1 <= rd_state_p0;
         rd_ptr_p1   <= rd_ptr_p0;
         rd_sel_p1   <= rd_sel_p0;
         rd_addr_p1  <= rd_addr_p0;
         rd_count_p1 <= rd_count_p0;
         rd_data_p1  <= rd_data_p0;
         rd_gnt_p1   <= rd_gnt_p0;
         rd_done_p1  <= rd_done_p0;
         rd_err_p1   <= rd_err_p0;
      end
   end

   assign wr_gnt_o       = wr_gnt_p1;
   assign wr_done_o      = wr_done_p1;
   assign wr_err_o       = wr_err_p1;
   assign rd_gnt_o       = rd_gnt_p1;
   assign rd_done_o      = rd_done_p1;
   assign rd_err_o       = rd_err_p1;
   assign rd_data_o      = rd_data_p1;
   assign mgr_req_o      = {rd_state_p1 == BUSY, wr_state_p1 == BUSY};
   assign mgr_wr_addr_o  = wr_addr_p1;
   assign mgr_rd_addr_o  = rd_addr_p1;
   assign mgr_data_o     = wr_data_p1;
   assign mgr_wr_count_o = wr_count_p1;
   assign mgr_rd_count_o = rd_count_p1;

endmodule

// File: tb/tb_axi4_mgr_arb.sv
// Randomized bench for axi4_mgr_arb: random clients on both channels, a random
// manager (completion pulses, including stray ones while idle), and random
// asynchronous resets while both channels are busy. A transaction-level
// reference model predicts every registered output.
module tb_axi4_mgr_arb;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int CW = 8;
   localparam int NCYC = 4000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstn;
   logic [N-1:0]      wr_req, rd_req;
   logic [N*AW-1:0]   wr_addr, rd_addr;
   logic [N*DW-1:0]   wr_data;
   logic [N*CW-1:0]   wr_count, rd_count;
   logic [N-1:0]      wr_gnt, wr_done, rd_gnt, rd_done;
   logic [1:0]        wr_err, rd_err;
   logic [DW-1:0]     rd_data;
   logic [1:0]        mgr_req;
   logic [AW-1:0]     mgr_wr_addr, mgr_rd_addr;
   logic [DW-1:0]     mgr_wdata;
   logic [CW-1:0]     mgr_wr_count, mgr_rd_count;
   logic [1:0]        mgr_rsp, mgr_wr_err, mgr_rd_err;
   logic [DW-1:0]     mgr_rdata;

   // client-side stimulus, channel 0 = write, 1 = read
   logic [N-1:0]      c_req [2];
   logic [AW-1:0]     c_addr [2][N];
   logic [CW-1:0]     c_count [2][N];
   logic [DW-1:0]     c_wdata [N];

   assign wr_req = c_req[0];
   assign rd_req = c_req[1];
   for (genvar g = 0; g < N; g++) begin : g_pack
      assign wr_addr[g*AW +: AW]  = c_addr[0][g];
      assign rd_addr[g*AW +: AW]  = c_addr[1][g];
      assign wr_count[g*CW +: CW] = c_count[0][g];
      assign rd_count[g*CW +: CW] = c_count[1][g];
      assign wr_data[g*DW +: DW]  = c_wdata[g];
   end

   axi4_mgr_arb #(
      .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DATA_COUNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rstn_i(rstn),
      .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_count_i(wr_count),
      .wr_gnt_o(wr_gnt), .wr_done_o(wr_done), .wr_err_o(wr_err),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_count_i(rd_count),
      .rd_gnt_o(rd_gnt), .rd_done_o(rd_done), .rd_err_o(rd_err), .rd_data_o(rd_data),
      .mgr_req_o(mgr_req), .mgr_wr_addr_o(mgr_wr_addr), .mgr_rd_addr_o(mgr_rd_addr),
      .mgr_data_o(mgr_wdata), .mgr_wr_count_o(mgr_wr_count), .mgr_rd_count_o(mgr_rd_count),
      .mgr_rsp_i(mgr_rsp), .mgr_wr_err_i(mgr_wr_err), .mgr_rd_err_i(mgr_rd_err),
      .mgr_data_i(mgr_rdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: one outstanding transfer per channel
   bit            m_busy [2];
   int            m_ptr [2];
   int            m_owner [2];
   logic [AW-1:0] m_addr [2];
   logic [CW-1:0] m_count [2];
   logic [DW-1:0] m_wdata, m_rdata;
   logic [N-1:0]  e_gnt [2];
   logic [N-1:0]  e_done [2];
   logic [1:0]    e_err [2];

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_busy[c] = 0; m_ptr[c] = 0; m_owner[c] = 0;
         m_addr[c] = '0; m_count[c] = '0;
         e_gnt[c] = '0; e_done[c] = '0; e_err[c] = '0;
      end
      m_wdata = '0;
      m_rdata = '0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      int best, bestd, d;
      for (int c = 0; c < 2; c++) begin
         e_gnt[c] = '0; e_done[c] = '0; e_err[c] = '0;
         if (m_busy[c]) begin
            if (mgr_rsp[c]) begin
               e_done[c][m_owner[c]] = 1'b1;
               e_err[c] = (c == 0) ? mgr_wr_err : mgr_rd_err;
               if (c == 1) m_rdata = mgr_rdata;
               m_busy[c] = 0;
            end
         end else begin
            best = -1; bestd = N;
            for (int k = 0; k < N; k++) begin
               d = (k - m_ptr[c] + N) % N;
               if (c_req[c][k] && d < bestd) begin best = k; bestd = d; end
            end
            if (best >= 0) begin
               e_gnt[c][best] = 1'b1;
               m_ptr[c]   = (best + 1) % N;
               m_owner[c] = best;
               m_addr[c]  = c_addr[c][best];
               m_count[c] = c_count[c][best];
               if (c == 0) m_wdata = c_wdata[best];
               if (c_count[c][best] == 0) begin
                  e_done[c][best] = 1'b1;
                  e_err[c] = 2'b10;
               end else begin
                  m_busy[c] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("wr_gnt", 64'(wr_gnt), 64'(e_gnt[0]));
      check("wr_done", 64'(wr_done), 64'(e_done[0]));
      check("wr_err", 64'(wr_err), 64'(e_err[0]));
      check("rd_gnt", 64'(rd_gnt), 64'(e_gnt[1]));
      check("rd_done", 64'(rd_done), 64'(e_done[1]));
      check("rd_err", 64'(rd_err), 64'(e_err[1]));
      check("rd_data", rd_data, m_rdata);
      check("mgr_req", 64'(mgr_req), 64'({m_busy[1], m_busy[0]}));
      check("mgr_wr_addr", 64'(mgr_wr_addr), 64'(m_addr[0]));
      check("mgr_rd_addr", 64'(mgr_rd_addr), 64'(m_addr[1]));
      check("mgr_data", mgr_wdata, m_wdata);
      check("mgr_wr_count", 64'(mgr_wr_count), 64'(m_count[0]));
      check("mgr_rd_count", 64'(mgr_rd_count), 64'(m_count[1]));
   endtask

   task automatic check_all_zero();
      check("rst_wr_gnt", 64'(wr_gnt), 64'd0);
      check("rst_wr_done", 64'(wr_done), 64'd0);
      check("rst_wr_err", 64'(wr_err), 64'd0);
      check("rst_rd_gnt", 64'(rd_gnt), 64'd0);
      check("rst_rd_done", 64'(rd_done), 64'd0);
      check("rst_rd_err", 64'(rd_err), 64'd0);
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_mgr_req", 64'(mgr_req), 64'd0);
      check("rst_mgr_wr_addr", 64'(mgr_wr_addr), 64'd0);
      check("rst_mgr_rd_addr", 64'(mgr_rd_addr), 64'd0);
      check("rst_mgr_data", mgr_wdata, 64'd0);
      check("rst_mgr_wr_count", 64'(mgr_wr_count), 64'd0);
      check("rst_mgr_rd_count", 64'(mgr_rd_count), 64'd0);
   endtask

   // New client and manager stimulus, applied away from the clock edge.
   task automatic drive_next();
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < N; k++) begin
            if (e_gnt[c][k]) begin
               c_req[c][k] = 1'b0;
            end else if (!c_req[c][k] && $urandom_range(0, 3) == 0) begin
               c_req[c][k]   = 1'b1;
               c_addr[c][k]  = $urandom;
               c_count[c][k] = ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom_range(1, 255));
               if (c == 0) c_wdata[k] = {$urandom, $urandom};
            end
         end
      end
      mgr_rsp    = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      mgr_wr_err = 2'($urandom);
      mgr_rd_err = 2'($urandom);
      mgr_rdata  = {$urandom, $urandom};
   endtask

   int next_rst = 600;

   initial begin
      rstn = 1'b0;
      for (int c = 0; c < 2; c++) begin
         c_req[c] = '0;
         for (int k = 0; k < N; k++) begin
            c_addr[c][k] = '0; c_count[c][k] = '0;
         end
      end
      for (int k = 0; k < N; k++) c_wdata[k] = '0;
      mgr_rsp = '0; mgr_wr_err = '0; mgr_rd_err = '0; mgr_rdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero();
      rstn = 1'b1;
      drive_next();
      mgr_rsp = 2'b11;                  // stale completion straight after reset release
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check_outputs();
         drive_next();
         if (cyc >= next_rst && m_busy[0] && m_busy[1]) begin
            next_rst = cyc + 600;
            #2 rstn = 1'b0;
            #1 check_all_zero();
            model_reset();
            @(posedge clk);
            @(negedge clk);
            check_all_zero();
            rstn = 1'b1;
            mgr_rsp = 2'b11;            // stale completion after release must be ignored
         end
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
